vp_validation_fifo: RTL

In-order tracking queue between the value predictor's prediction interface and its feedback interface. It captures every valid prediction (PC, predicted value, confidence) as it leaves the predictor and holds it until the execution stage returns the true result, in program order. It then compares actual against predicted and drives the predictor's feedback ports (PC, actual, mispredict, confidence, valid) one cycle later.

---
 rtl/vp_pkg.sv | 30 +++
 rtl/vp_validation_fifo.sv | 121 ++++++++++++
 2 files changed

// File: rtl/vp_pkg.sv
// Shared types and lane helpers for the value predictor's validation queue.
// Helpers operate on a fixed 2-lane vector; narrower lane counts zero-extend into it.
package vp_pkg;

   localparam int VP_MAX_LANES = 2;

   typedef struct packed {
      logic [31:1] pc;
      logic [31:0] result;
      logic        conf;
   } vp_entry_t;

   function automatic logic [1:0] vp_popcount(input logic [VP_MAX_LANES-1:0] valid);
      return 2'(valid[0]) + 2'(valid[1]);
   endfunction

   // Compacted slot of a lane: how many valid lanes sit below it.
   function automatic logic [1:0] vp_lane_slot(input logic [VP_MAX_LANES-1:0] valid,
                                               input int lane);
      logic [1:0] slot;
      slot = '0;
      for (int i = 0; i < VP_MAX_LANES; i++) begin
         if (i < lane && valid[i]) begin
            slot = slot + 2'd1;
         end
      end
      return slot;
   endfunction

endpackage

// File: rtl/vp_validation_fifo.sv
// In-order queue pairing value predictions with their execution results and
// producing registered predictor feedback one cycle after the result arrives.
module vp_validation_fifo
   import vp_pkg::*;
#(
   parameter int P_NUM_PRED   = 2,
   parameter int P_FIFO_DEPTH = 16,
   localparam int P_CNT_WIDTH = $clog2(P_FIFO_DEPTH) + 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic [P_NUM_PRED-1:0][31:1]  pred_pc_i,
   input  logic [P_NUM_PRED-1:0][31:0]  pred_result_i,
   input  logic [P_NUM_PRED-1:0]        pred_conf_i,
   input  logic [P_NUM_PRED-1:0]        pred_valid_i,
   output logic                         pred_ready_o,
   input  logic [P_NUM_PRED-1:0][31:0]  exe_actual_i,
   input  logic [P_NUM_PRED-1:0]        exe_valid_i,
   output logic [P_NUM_PRED-1:0][31:1]  fb_pc_o,
   output logic [P_NUM_PRED-1:0][31:0]  fb_actual_o,
   output logic [P_NUM_PRED-1:0]        fb_mispredict_o,
   output logic [P_NUM_PRED-1:0]        fb_conf_o,
   output logic [P_NUM_PRED-1:0]        fb_valid_o,
   output logic [P_CNT_WIDTH-1:0]       count_o,
   output logic                         drop_o,
   output logic                         underflow_o
);

   localparam int PTR_W = $clog2(P_FIFO_DEPTH);

   vp_entry_t              mem [P_FIFO_DEPTH];
   vp_entry_t              rd_entry [P_NUM_PRED];
   logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
   logic [P_CNT_WIDTH-1:0] count_q, nenq, nres, ndeq;
   logic [1:0]             pred_valid_w, exe_valid_w;
   logic                   enq_fire;

   assign pred_valid_w = 2'(pred_valid_i);
   assign exe_valid_w  = 2'(exe_valid_i);
   assign count_o      = count_q;

   // Ready depends on the count register alone, so no input reaches it combinationally.
   assign pred_ready_o = (count_q <= P_CNT_WIDTH'(P_FIFO_DEPTH - P_NUM_PRED));
   assign enq_fire     = pred_ready_o && !flush_i;

   always_comb begin
      nenq = enq_fire ? P_CNT_WIDTH'(vp_popcount(pred_valid_w)) : '0;
      nres = P_CNT_WIDTH'(vp_popcount(exe_valid_w));
      if (flush_i) begin
         ndeq = '0;
      end else if (nres > count_q) begin
         ndeq = count_q;
      end else begin
         ndeq = nres;
      end
   end

   always_comb begin
      for (int k = 0; k < P_NUM_PRED; k++) begin
         rd_entry[k] = mem[rd_ptr_q + PTR_W'(k)];
      end
   end

   // Storage is deliberately left unreset; valid entries are tracked by count and pointers.
   always_ff @(posedge clk_i) begin
      if (enq_fire) begin
         for (int l = 0; l < P_NUM_PRED; l++) begin
            if (pred_valid_i[l]) begin
               mem[wr_ptr_q + PTR_W'(vp_lane_slot(pred_valid_w, l))] <= '{
                  pc:     pred_pc_i[l],
                  result: pred_result_i[l],
                  conf:   pred_conf_i[l]
               };
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         fb_pc_o         <= '0;
         fb_actual_o     <= '0;
         fb_mispredict_o <= '0;
         fb_conf_o       <= '0;
         fb_valid_o      <= '0;
         drop_o          <= 1'b0;
         underflow_o     <= 1'b0;
      end else if (flush_i) begin
         rd_ptr_q        <= '0;
         wr_ptr_q        <= '0;
         count_q         <= '0;
         fb_actual_o     <= exe_actual_i;
         fb_mispredict_o <= '0;
         fb_valid_o      <= '0;
         drop_o          <= 1'b0;
         underflow_o     <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_q + PTR_W'(nenq);
         rd_ptr_q    <= rd_ptr_q + PTR_W'(ndeq);
         count_q     <= count_q + nenq - ndeq;
         fb_actual_o <= exe_actual_i;
         drop_o      <= !pred_ready_o && (|pred_valid_i);
         underflow_o <= (nres > count_q);
         for (int k = 0; k < P_NUM_PRED; k++) begin
            fb_valid_o[k] <= (P_CNT_WIDTH'(k) < ndeq);
            if (P_CNT_WIDTH'(k) < ndeq) begin
               fb_mispredict_o[k] <= (exe_actual_i[k] != rd_entry[k].result);
               fb_pc_o[k]         <= rd_entry[k].pc;
               fb_conf_o[k]       <= rd_entry[k].conf;
            end else begin
               fb_mispredict_o[k] <= 1'b0;
            end
         end
      end
   end

endmodule
